// File: rtl/bram_rmw_ctrl_if.sv
// -----------------------------------------------------------------------------
// bram_rmw_ctrl_if
// Bundle of every bus signal around the BRAM request controller: the core-side
// valid/ready request channel with its response, and the BRAM read/write ports.
//
// Modports
//   slave  : controller view (takes requests, drives the BRAM ports)
//   master : environment view (core issuing requests + BRAM returning readData)
//
// Signals
//   reqValid/reqReady            request handshake
//   reqWrite                     1 = store, 0 = load
//   reqAddress                   word address
//   reqWriteData/reqByteEnable   store data and byte mask (bit i -> byte i)
//   respValid/respReadData       one-cycle response pulse, load data
//   memReadEnable/memReadAddress BRAM read port request
//   memReadData                  BRAM registered read data (cycle after enable)
//   memWriteEnable/memWriteAddress/memWriteData  BRAM write port
// -----------------------------------------------------------------------------
interface bram_rmw_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    reqValid;
  logic                    reqReady;
  logic                    reqWrite;
  logic [ADDR_WIDTH-1:0]   reqAddress;
  logic [DATA_WIDTH-1:0]   reqWriteData;
  logic [DATA_WIDTH/8-1:0] reqByteEnable;
  logic                    respValid;
  logic [DATA_WIDTH-1:0]   respReadData;
  logic                    memReadEnable;
  logic [ADDR_WIDTH-1:0]   memReadAddress;
  logic [DATA_WIDTH-1:0]   memReadData;
  logic                    memWriteEnable;
  logic [ADDR_WIDTH-1:0]   memWriteAddress;
  logic [DATA_WIDTH-1:0]   memWriteData;

  modport slave (
    input  reqValid, reqWrite, reqAddress, reqWriteData, reqByteEnable, memReadData,
    output reqReady, respValid, respReadData,
    output memReadEnable, memReadAddress, memWriteEnable, memWriteAddress, memWriteData
  );

  modport master (
    output reqValid, reqWrite, reqAddress, reqWriteData, reqByteEnable, memReadData,
    input  reqReady, respValid, respReadData,
    input  memReadEnable, memReadAddress, memWriteEnable, memWriteAddress, memWriteData
  );
endinterface

// File: rtl/bram_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// bram_rmw_ctrl
// Request-side controller for a BRAM with one read and one write port.
// Takes one load/store at a time, drives the BRAM ports from registers and
// returns exactly one respValid pulse per accepted request.
//
// Optional feature macro: BRAM_RMW_BYTE_WRITE_EN
//   defined   : partial byte masks become read-modify-write (read, merge, write);
//               an all-zero mask answers without touching the BRAM.
//   undefined : reqByteEnable is ignored, every store is a full-word write.
//
// Ports
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : bram_rmw_ctrl_if.slave (request/response channel + BRAM ports)
//
// Timing after the accept edge T: load resp at T+2, full store write+resp at
// T+1, partial store read at T+1, merge at T+2, write+resp at T+3.
// -----------------------------------------------------------------------------
module bram_rmw_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic           clock,
  input  logic           reset,
  bram_rmw_ctrl_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ISSUE  = 3'd1,
    RD_RESP   = 3'd2,
`ifdef BRAM_RMW_BYTE_WRITE_EN
    RMW_ISSUE = 3'd3,
    RMW_MERGE = 3'd4,
`endif
    WR_ACK    = 3'd5
  } state_e;

  state_e                state_q;
  logic                  ready_q;
  logic                  resp_valid_q;
  logic                  mem_re_q;
  logic [ADDR_WIDTH-1:0] mem_raddr_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_waddr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  accept_s;

`ifdef BRAM_RMW_BYTE_WRITE_EN
  // Holding registers: the merge happens two cycles after the request left.
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]      be_q;

  // Byte merge: new byte where the mask bit is set, otherwise the stored byte.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [BYTES-1:0]      mask
  );
    logic [DATA_WIDTH-1:0] m;
    m = old_word;
    for (int i = 0; i < BYTES; i++) begin
      if (mask[i]) begin
        m[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        m[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return m;
  endfunction
`else
  // Mask has no meaning in the full-word build.
  logic unused_be_s;
  assign unused_be_s = ^bus.reqByteEnable;
`endif

  assign accept_s = bus.reqValid & ready_q;

  // ready_q rests at 1 through reset so the first post-reset cycle can accept;
  // the reset term keeps reqReady low while reset is applied.
  assign bus.reqReady        = ready_q & ~reset;
  assign bus.respValid       = resp_valid_q;
  // BRAM data only lands in the response cycle, so it is steered, not stored.
  assign bus.respReadData    = ((state_q == RD_RESP) && !reset) ? bus.memReadData
                                                                : {DATA_WIDTH{1'b0}};
  assign bus.memReadEnable   = mem_re_q;
  assign bus.memReadAddress  = mem_raddr_q;
  assign bus.memWriteEnable  = mem_we_q;
  assign bus.memWriteAddress = mem_waddr_q;
  assign bus.memWriteData    = mem_wdata_q;

  // Controller FSM: state, handshake flags and every BRAM-facing register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_raddr_q  <= {ADDR_WIDTH{1'b0}};
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q  <= {DATA_WIDTH{1'b0}};
`ifdef BRAM_RMW_BYTE_WRITE_EN
      addr_q       <= {ADDR_WIDTH{1'b0}};
      wdata_q      <= {DATA_WIDTH{1'b0}};
      be_q         <= {BYTES{1'b0}};
`endif
    end else begin
      // Enables and the response are single-cycle pulses.
      resp_valid_q <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            ready_q <= 1'b0;
`ifdef BRAM_RMW_BYTE_WRITE_EN
            addr_q  <= bus.reqAddress;
            wdata_q <= bus.reqWriteData;
            be_q    <= bus.reqByteEnable;
`endif
            if (!bus.reqWrite) begin
              state_q     <= RD_ISSUE;
              mem_re_q    <= 1'b1;
              mem_raddr_q <= bus.reqAddress;
`ifdef BRAM_RMW_BYTE_WRITE_EN
            end else if (&bus.reqByteEnable) begin
              state_q      <= WR_ACK;
              mem_we_q     <= 1'b1;
              mem_waddr_q  <= bus.reqAddress;
              mem_wdata_q  <= bus.reqWriteData;
              resp_valid_q <= 1'b1;
            end else if (|bus.reqByteEnable) begin
              state_q     <= RMW_ISSUE;
              mem_re_q    <= 1'b1;
              mem_raddr_q <= bus.reqAddress;
            end else begin
              // Empty mask: acknowledge without any BRAM access.
              state_q      <= WR_ACK;
              resp_valid_q <= 1'b1;
            end
`else
            end else begin
              state_q      <= WR_ACK;
              mem_we_q     <= 1'b1;
              mem_waddr_q  <= bus.reqAddress;
              mem_wdata_q  <= bus.reqWriteData;
              resp_valid_q <= 1'b1;
            end
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RD_ISSUE: begin
          state_q      <= RD_RESP;
          resp_valid_q <= 1'b1;
        end
        RD_RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
`ifdef BRAM_RMW_BYTE_WRITE_EN
        RMW_ISSUE: begin
          state_q <= RMW_MERGE;
        end
        RMW_MERGE: begin
          // memReadData is valid now (read issued one cycle ago).
          state_q      <= WR_ACK;
          mem_we_q     <= 1'b1;
          mem_waddr_q  <= addr_q;
          mem_wdata_q  <= merge_bytes(wdata_q, bus.memReadData, be_q);
          resp_valid_q <= 1'b1;
        end
`endif
        WR_ACK: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bram_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_rmw_ctrl
// Self-checking bench: a BRAM model on the memory ports, a word-array reference
// memory updated by byte-mask rules, a directed vector table, hand-written
// back-to-back and reset-abort sequences, then randomized requests.
// -----------------------------------------------------------------------------
module tb_bram_rmw_ctrl;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int BW = DW / 8;
`ifdef BRAM_RMW_BYTE_WRITE_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_rmw_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_rmw_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // BRAM model: registered read, write committed at the edge.
  logic [DW-1:0] bram [0:255];
  logic [DW-1:0] bram_rdata = '0;
  assign bus.memReadData = bram_rdata;
  always @(posedge clk) begin
    if (bus.memReadEnable) bram_rdata <= bram[bus.memReadAddress];
    if (bus.memWriteEnable) bram[bus.memWriteAddress] <= bus.memWriteData;
  end

  // Reference memory.
  logic [DW-1:0] ref_mem [0:255];

  int n_cmp = 0;
  int n_bad = 0;
  int both_cnt = 0;
  int resp_cnt = 0;
  int wr_cnt = 0;

  // Global monitors.
  always @(negedge clk) begin
    if (bus.memReadEnable && bus.memWriteEnable) both_cnt++;
    if (bus.respValid) resp_cnt++;
    if (bus.memWriteEnable) wr_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Store effect from the byte-mask rules.
  function automatic logic [DW-1:0] ref_after_store(input logic [DW-1:0] old_w,
                                                    input logic [DW-1:0] new_w,
                                                    input logic [BW-1:0] be);
    logic [DW-1:0] r;
    if (!BE_EN) return new_w;
    r = old_w;
    for (int i = 0; i < BW; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // Response latency after the accept edge.
  function automatic int ref_lat(input logic wr, input logic [BW-1:0] be);
    if (!wr) return 2;
    if (BE_EN && be != '0 && be != '1) return 3;
    return 1;
  endfunction

  task automatic backdoor(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bram[a] = v;
    ref_mem[a] = v;
  endtask

  // One request from idle, watched for 8 cycles after the accept edge.
  task automatic do_req(input string tag, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be,
                        output logic [DW-1:0] got);
    int guard, lat, rcyc, wcyc, npulse, nwr, elat, ercyc, ewcyc;
    logic [AW-1:0] raddr, waddr;
    logic [DW-1:0] wval, exp_new;
    logic ewr;
    elat  = ref_lat(wr, be);
    ewr   = wr && (!BE_EN || be != '0);
    ewcyc = ewr ? elat : 0;
    ercyc = (!wr || (BE_EN && be != '0 && be != '1)) ? 1 : 0;
    exp_new = ref_after_store(ref_mem[a], d, be);
    lat = 0; rcyc = 0; wcyc = 0; npulse = 0; nwr = 0;
    raddr = '0; waddr = '0; wval = '0; got = '0;
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqWrite = wr; bus.reqAddress = a;
    bus.reqWriteData = d; bus.reqByteEnable = be;
    guard = 0;
    while (!bus.reqReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, ".accepted"}, 64'(guard < 20), 64'd1);
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    bus.reqWrite = 1'($urandom);
    bus.reqAddress = AW'($urandom);
    bus.reqWriteData = $urandom;
    bus.reqByteEnable = BW'($urandom);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.memReadEnable && rcyc == 0) begin rcyc = k; raddr = bus.memReadAddress; end
      if (bus.memWriteEnable) begin
        nwr++;
        if (wcyc == 0) begin wcyc = k; waddr = bus.memWriteAddress; wval = bus.memWriteData; end
      end
      if (bus.respValid) begin
        npulse++;
        if (lat == 0) begin lat = k; got = bus.respReadData; end
      end
      if (k == elat) chk({tag, ".ready_busy"}, 64'(bus.reqReady), 64'd0);
      if (k == elat + 1) chk({tag, ".ready_back"}, 64'(bus.reqReady), 64'd1);
    end
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".pulses"}, 64'(npulse), 64'd1);
    chk({tag, ".rdata"}, 64'(got), wr ? 64'd0 : 64'(ref_mem[a]));
    chk({tag, ".rd_cycle"}, 64'(rcyc), 64'(ercyc));
    if (rcyc != 0) chk({tag, ".rd_addr"}, 64'(raddr), 64'(a));
    chk({tag, ".wr_cycle"}, 64'(wcyc), 64'(ewcyc));
    chk({tag, ".wr_count"}, 64'(nwr), 64'(ewr ? 1 : 0));
    if (wcyc != 0) begin
      chk({tag, ".wr_addr"}, 64'(waddr), 64'(a));
      chk({tag, ".wr_data"}, 64'(wval), 64'(exp_new));
    end
    if (wr) ref_mem[a] = exp_new;
    chk({tag, ".mem"}, 64'(bram[a]), 64'(ref_mem[a]));
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] got;
    int acc_t[3];
    int rsp_t[3];
    logic [DW-1:0] rsp_d[3];
    int na, nr, r0, w0;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [BW-1:0] rb;
    logic rw;

    for (int i = 0; i < 256; i++) begin bram[i] = '0; ref_mem[i] = '0; end
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqAddress = '0;
    bus.reqWriteData = '0; bus.reqByteEnable = '0;

    tbl[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 4'b1111, 32'h0};
    tbl[1] = '{1'b0, 8'h10, 32'h0,        4'b0000, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, 32'h0};
    tbl[3] = '{1'b0, 8'h20, 32'h0,        4'b0000, BE_EN ? 32'h11BB33DD : 32'hAABBCCDD};
    tbl[4] = '{1'b1, 8'h05, 32'h12345678, 4'b0000, 32'h0};
    tbl[5] = '{1'b0, 8'h05, 32'h0,        4'b0000, BE_EN ? 32'hCAFEF00D : 32'h12345678};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.reqReady", 64'(bus.reqReady), 64'd0);
    chk("rst.respValid", 64'(bus.respValid), 64'd0);
    chk("rst.memReadEnable", 64'(bus.memReadEnable), 64'd0);
    chk("rst.memWriteEnable", 64'(bus.memWriteEnable), 64'd0);
    chk("rst.respReadData", 64'(bus.respReadData), 64'd0);
    chk("rst.memReadAddress", 64'(bus.memReadAddress), 64'd0);
    chk("rst.memWriteAddress", 64'(bus.memWriteAddress), 64'd0);
    chk("rst.memWriteData", 64'(bus.memWriteData), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst.reqReady", 64'(bus.reqReady), 64'd1);
    chk("post_rst.respValid", 64'(bus.respValid), 64'd0);
    chk("post_rst.memWriteEnable", 64'(bus.memWriteEnable), 64'd0);

    // Directed vector table.
    backdoor(8'h20, 32'h11223344);
    backdoor(8'h05, 32'hCAFEF00D);
    for (int i = 0; i < 6; i++) begin
      do_req($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].be, got);
      chk($sformatf("tbl%0d.expected_data", i), 64'(got), 64'(tbl[i].exp_rd));
    end

    // Back-to-back with reqValid held: load, full store, load on one address.
    backdoor(8'h30, 32'h01020304);
    na = 0; nr = 0;
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqAddress = 8'h30;
    bus.reqWriteData = '0; bus.reqByteEnable = '0;
    for (int c = 0; c < 14; c++) begin
      if (bus.respValid) begin
        if (nr < 3) begin rsp_t[nr] = c; rsp_d[nr] = bus.respReadData; end
        nr++;
      end
      if (bus.reqValid && bus.reqReady) begin
        if (na < 3) acc_t[na] = c;
        na++;
        @(posedge clk);
        #1;
        if (na == 1) begin
          bus.reqWrite = 1'b1; bus.reqWriteData = 32'hA5A55A5A; bus.reqByteEnable = 4'b1111;
        end else if (na == 2) begin
          bus.reqWrite = 1'b0; bus.reqWriteData = '0; bus.reqByteEnable = '0;
        end else begin
          bus.reqValid = 1'b0;
        end
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    chk("b2b.accepts", 64'(na), 64'd3);
    chk("b2b.pulses", 64'(nr), 64'd3);
    // load 2 cycles + idle, store 1 cycle + idle, then load.
    if (na == 3 && nr == 3) begin
      chk("b2b.acc1", 64'(acc_t[1]), 64'd3);
      chk("b2b.acc2", 64'(acc_t[2]), 64'd5);
      chk("b2b.rsp0", 64'(rsp_t[0]), 64'd2);
      chk("b2b.rsp1", 64'(rsp_t[1]), 64'd4);
      chk("b2b.rsp2", 64'(rsp_t[2]), 64'd7);
      chk("b2b.data0", 64'(rsp_d[0]), 64'h01020304);
      chk("b2b.data1", 64'(rsp_d[1]), 64'd0);
      chk("b2b.data2", 64'(rsp_d[2]), 64'hA5A55A5A);
    end
    ref_mem[8'h30] = 32'hA5A55A5A;

    // Reset mid-operation: merge cycle of a partial store, or the read issue of a load.
    backdoor(8'h40, 32'h0BADF00D);
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqWrite = BE_EN; bus.reqAddress = 8'h40;
    bus.reqWriteData = 32'h55667788; bus.reqByteEnable = 4'b0011;
    chk("abort.ready", 64'(bus.reqReady), 64'd1);
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    r0 = resp_cnt; w0 = wr_cnt;
    @(negedge clk);
    if (BE_EN) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort.no_resp", 64'(resp_cnt - r0), 64'd0);
    chk("abort.no_write", 64'(wr_cnt - w0), 64'd0);
    chk("abort.mem", 64'(bram[8'h40]), 64'h0BADF00D);
    chk("abort.idle_ready", 64'(bus.reqReady), 64'd1);
    do_req("abort.follow", 1'b0, 8'h40, 32'h0, 4'b0000, got);

    // Randomized requests on a small address window.
    for (int i = 0; i < 50; i++) begin
      rw = 1'($urandom);
      ra = 8'h60 + AW'($urandom_range(7, 0));
      rd = $urandom;
      rb = BW'($urandom);
      do_req($sformatf("rnd%0d", i), rw, ra, rd, rb, got);
    end

    chk("rw_exclusive", 64'(both_cnt), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
